cpu_step_controller: RTL

Execution-control stage directly downstream of the frequency divider. Consumes the divider's slow square wave (`slow_clk`) and emits single-cycle clock-enable pulses (`cpu_en`) for the processor core, all in the C_50Mhz domain.
- Supports free-run (one pulse per slow_clk rising edge), debounced single-step from a push-button, and halt.
- Halt is entered either from the mode switches or from the core's `halt_req`.

---
 rtl/cpu_step_controller_if.sv | 26 ++
 rtl/cpu_step_controller.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cpu_step_controller_if.sv
// Signal bundle between the execution-control stage and its surroundings:
// divider clock, operator controls and core handshake.
// The controller connects through the master modport; the environment that
// drives the controls and observes the enables uses the slave modport.
interface cpu_step_controller_if #(
  parameter int CNT_W = 16
) ();
  logic             slow_clk;
  logic [1:0]       mode;
  logic             step_btn;
  logic             halt_req;
  logic             cpu_en;
  logic             running;
  logic [CNT_W-1:0] step_count;
  logic [1:0]       state_o;

  modport master (
    input  slow_clk, mode, step_btn, halt_req,
    output cpu_en, running, step_count, state_o
  );

  modport slave (
    output slow_clk, mode, step_btn, halt_req,
    input  cpu_en, running, step_count, state_o
  );
endinterface

// File: rtl/cpu_step_controller.sv
// Execution-control stage: turns the divider's slow square wave and a
// debounced push-button into single-cycle clock enables for the core.
// Modes: free-run (one enable per slow_clk rising edge), single-step and halt.
// Optional macro STEP_BURST_EN: each button press in STEP releases a burst of
// BURST_LEN enables, paced by slow_clk ticks, instead of a single enable.
module cpu_step_controller #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = 16,
  parameter int BURST_LEN       = 4
) (
  input  logic                 C_50Mhz,
  input  logic                 reset,
  cpu_step_controller_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  localparam logic [1:0] MODE_HALT0 = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;

  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_q, state_d;
  logic             btn_meta, btn_s;
  logic             db_level, db_level_prev;
  logic [DB_W-1:0]  db_cnt;
  logic             slow_prev;
  logic             tick, step_pulse, step_fire;
  logic             cpu_en_d;
  logic             cpu_en_q, running_q;
  logic [CNT_W-1:0] step_count_q;

  // Synchronize the raw button and require DEBOUNCE_CYCLES stable samples
  // before the debounced level follows it.
  always_ff @(posedge C_50Mhz) begin
    if (reset) begin
      btn_meta      <= 1'b0;
      btn_s         <= 1'b0;
      db_level      <= 1'b0;
      db_level_prev <= 1'b0;
      db_cnt        <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // so the two synchronizer stages really are two cycles apart.
      btn_meta      <= bus.step_btn;
      btn_s         <= btn_meta;
      db_level_prev <= db_level;
      if (btn_s == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= btn_s;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Remember last cycle's slow_clk so its rising edge can be detected.
  always_ff @(posedge C_50Mhz) begin
    if (reset) slow_prev <= 1'b0;
    else       slow_prev <= bus.slow_clk;
  end

  assign tick       = bus.slow_clk & ~slow_prev;
  assign step_pulse = db_level & ~db_level_prev;

`ifdef STEP_BURST_EN
  logic [7:0] burst_q;
  logic       burst_fire;

  assign burst_fire = (state_q == STEP) && (burst_q != 8'd0) && tick && !bus.halt_req;
  assign step_fire  = burst_fire;

  // Burst counter: loaded by a press in STEP, spent one per tick, dropped on
  // halt or whenever the next state is not STEP.
  always_ff @(posedge C_50Mhz) begin
    if (reset) begin
      burst_q <= 8'd0;
    end else if (bus.halt_req || (state_d != STEP)) begin
      burst_q <= 8'd0;
    end else if (burst_fire) begin
      burst_q <= burst_q - 8'd1;
    end else if (step_pulse && (burst_q == 8'd0) && (state_q == STEP)) begin
      burst_q <= 8'(BURST_LEN);
    end
  end
`else
  logic unused_burst_len;

  assign unused_burst_len = ^BURST_LEN;
  assign step_fire        = (state_q == STEP) && step_pulse && !bus.halt_req;
`endif

  // State register.
  always_ff @(posedge C_50Mhz) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection from mode and halt_req, plus the enable decision,
  // both made from the state registered this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d  = state_q;
    cpu_en_d = !bus.halt_req && (((state_q == RUN) && tick) || step_fire);

    if ((state_q != HALTED) && bus.halt_req) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.mode == MODE_RUN)       state_d = RUN;
          else if (bus.mode == MODE_STEP) state_d = STEP;
        end
        RUN: begin
          if (bus.mode == MODE_STEP)     state_d = STEP;
          else if (bus.mode != MODE_RUN) state_d = IDLE;
        end
        STEP: begin
          if (bus.mode == MODE_RUN)       state_d = RUN;
          else if (bus.mode != MODE_STEP) state_d = IDLE;
        end
        HALTED: begin
          if ((bus.mode == MODE_HALT0) && !bus.halt_req) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered outputs: enable pulse, RUN flag from next state and a
  // saturating count of issued enables.
  always_ff @(posedge C_50Mhz) begin
    if (reset) begin
      cpu_en_q     <= 1'b0;
      running_q    <= 1'b0;
      step_count_q <= '0;
    end else begin
      cpu_en_q  <= cpu_en_d;
      running_q <= (state_d == RUN);
      if (cpu_en_d && (step_count_q != '1)) step_count_q <= step_count_q + 1'b1;
    end
  end

  assign bus.cpu_en     = cpu_en_q;
  assign bus.running    = running_q;
  assign bus.step_count = step_count_q;
  assign bus.state_o    = state_q;

endmodule
